// File: rtl/avmm_csr_responder.sv
// Avalon-MM CSR responder: one outstanding access, waitrequest-stretched, delayed readdatavalid.
// Build option: AVMM_RESP_DECERR_EN makes unmapped reads return 32'hBADA_DD00 instead of zero.
module avmm_csr_responder #(
   parameter int unsigned AVMM_WIDTH  = 32,
   parameter int unsigned BYTE_WIDTH  = 4,
   parameter int unsigned NUM_REGS    = 16,
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned RD_LATENCY  = 1,
   parameter logic [AVMM_WIDTH-1:0] ID_VALUE = 32'h0A1B_0002
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [16:0]                    address_i,
   input  logic                           read_i,
   input  logic                           write_i,
   input  logic [AVMM_WIDTH-1:0]          writedata_i,
   input  logic [BYTE_WIDTH-1:0]          byteenable_i,
   output logic [AVMM_WIDTH-1:0]          readdata_o,
   output logic                           readdatavalid_o,
   output logic                           waitrequest_o,
   output logic [NUM_REGS*AVMM_WIDTH-1:0] csr_out_o
);

   localparam int unsigned Shift = $clog2(BYTE_WIDTH);
   localparam int unsigned IdxW  = $clog2(NUM_REGS);
   localparam int unsigned Reps  = (AVMM_WIDTH + 31) / 32;

`ifdef AVMM_RESP_DECERR_EN
   localparam logic [AVMM_WIDTH-1:0] UnmappedVal = AVMM_WIDTH'({Reps{32'hBADA_DD00}});
`else
   localparam logic [AVMM_WIDTH-1:0] UnmappedVal = '0;
`endif

   typedef enum logic [2:0] {StIdle, StWait, StAck, StRlat, StRdv} state_e;

   state_e                  state_q;
   logic [3:0]              cnt_q;
   logic [16:0]             addr_q;
   logic                    wr_q;
   logic [AVMM_WIDTH-1:0]   wdata_q;
   logic [BYTE_WIDTH-1:0]   be_q;
   logic [AVMM_WIDTH-1:0]   rd_val_q;
   logic [AVMM_WIDTH-1:0]   readdata_q;
   logic                    readdatavalid_q;
   logic                    waitrequest_q;
   logic [AVMM_WIDTH-1:0]   regs_q [NUM_REGS];

   logic [16:0]             idx;
   logic                    mapped;
   logic                    wr_ok;
   logic [AVMM_WIDTH-1:0]   rd_word;

   assign idx     = addr_q >> Shift;
   assign mapped  = (32'(idx) < NUM_REGS);
   assign wr_ok   = mapped && (idx != '0);
   assign rd_word = mapped ? regs_q[idx[IdxW-1:0]] : UnmappedVal;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q         <= StIdle;
         cnt_q           <= '0;
         addr_q          <= '0;
         wr_q            <= 1'b0;
         wdata_q         <= '0;
         be_q            <= '0;
         rd_val_q        <= '0;
         readdata_q      <= '0;
         readdatavalid_q <= 1'b0;
         waitrequest_q   <= 1'b1;
         regs_q[0]       <= ID_VALUE;
         for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         readdatavalid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (read_i || write_i) begin
                  addr_q  <= address_i;
                  wr_q    <= write_i;
                  wdata_q <= writedata_i;
                  be_q    <= byteenable_i;
                  if (WAIT_CYCLES > 0) begin
                     state_q <= StWait;
                     cnt_q   <= 4'(WAIT_CYCLES - 1);
                  end else begin
                     state_q       <= StAck;
                     waitrequest_q <= 1'b0;
                  end
               end
            end
            StWait: begin
               if (cnt_q == '0) begin
                  state_q       <= StAck;
                  waitrequest_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StAck: begin
               waitrequest_q <= 1'b1;
               if (wr_q) begin
                  if (wr_ok) begin
                     for (int k = 0; k < BYTE_WIDTH; k++) begin
                        if (be_q[k]) regs_q[idx[IdxW-1:0]][k*8 +: 8] <= wdata_q[k*8 +: 8];
                     end
                  end
                  state_q <= StIdle;
               end else begin
                  // Snapshot at ACK; nothing can write the bank until RDV completes.
                  rd_val_q <= rd_word;
                  if (RD_LATENCY > 1) begin
                     state_q <= StRlat;
                     cnt_q   <= 4'(RD_LATENCY - 2);
                  end else begin
                     state_q         <= StRdv;
                     readdata_q      <= rd_word;
                     readdatavalid_q <= 1'b1;
                  end
               end
            end
            StRlat: begin
               if (cnt_q == '0) begin
                  state_q         <= StRdv;
                  readdata_q      <= rd_val_q;
                  readdatavalid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StRdv: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign readdata_o      = readdata_q;
   assign readdatavalid_o = readdatavalid_q;
   assign waitrequest_o   = waitrequest_q;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_csr
      assign csr_out_o[g*AVMM_WIDTH +: AVMM_WIDTH] = regs_q[g];
   end

endmodule

// File: tb/tb_avmm_csr_responder.sv
// Scoreboard bench for avmm_csr_responder across three WAIT_CYCLES/RD_LATENCY configurations.
module tb_avmm_csr_responder;

   localparam int N = 3;
   localparam logic [31:0] IdVal = 32'h0A1B_0002;
`ifdef AVMM_RESP_DECERR_EN
   localparam logic [31:0] Unm = 32'hBADA_DD00;
`else
   localparam logic [31:0] Unm = 32'h0000_0000;
`endif

   typedef struct {
      bit          wr;
      bit          rd;
      logic [16:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [16:0]   address    [N];
   logic          read       [N];
   logic          write      [N];
   logic [31:0]   writedata  [N];
   logic [3:0]    byteenable [N];
   logic [31:0]   readdata   [N];
   logic          rdv        [N];
   logic          waitreq    [N];
   logic [511:0]  csr        [N];

   int wc [N] = '{1, 0, 3};
   int rl [N] = '{1, 1, 4};

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [31:0] sb_data [N][$];
   int          sb_cyc  [N][$];
   vec_t        vecs [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   avmm_csr_responder #(.WAIT_CYCLES(1), .RD_LATENCY(1)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .address_i(address[0]), .read_i(read[0]), .write_i(write[0]),
      .writedata_i(writedata[0]), .byteenable_i(byteenable[0]), .readdata_o(readdata[0]),
      .readdatavalid_o(rdv[0]), .waitrequest_o(waitreq[0]), .csr_out_o(csr[0])
   );
   avmm_csr_responder #(.WAIT_CYCLES(0), .RD_LATENCY(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .address_i(address[1]), .read_i(read[1]), .write_i(write[1]),
      .writedata_i(writedata[1]), .byteenable_i(byteenable[1]), .readdata_o(readdata[1]),
      .readdatavalid_o(rdv[1]), .waitrequest_o(waitreq[1]), .csr_out_o(csr[1])
   );
   avmm_csr_responder #(.WAIT_CYCLES(3), .RD_LATENCY(4)) u_dut2 (
      .clk_i(clk), .rst_i(rst), .address_i(address[2]), .read_i(read[2]), .write_i(write[2]),
      .writedata_i(writedata[2]), .byteenable_i(byteenable[2]), .readdata_o(readdata[2]),
      .readdatavalid_o(rdv[2]), .waitrequest_o(waitreq[2]), .csr_out_o(csr[2])
   );

   task automatic check(input string name, input int d, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d: got %h, expected %h", name, d, act, exp);
      end
   endtask

   // Monitor: every readdatavalid pulse must match the oldest pending read.
   always @(negedge clk) begin
      for (int d = 0; d < N; d++) begin
         if (rdv[d] === 1'b1) begin
            if (sb_data[d].size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_rdv dut%0d: got readdatavalid=1, expected 0", d);
            end else begin
               check("rd_data", d, readdata[d], sb_data[d].pop_front());
               check("rd_cycle", d, cyc, sb_cyc[d].pop_front());
            end
         end
      end
   end

   task automatic add(input bit wr, input bit rd, input logic [16:0] addr,
                      input logic [31:0] data, input logic [3:0] be, input logic [31:0] exp);
      vec_t v;
      v.wr = wr; v.rd = rd; v.addr = addr; v.data = data; v.be = be; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic run_vec(input int d, input vec_t v);
      int n;
      int idx;
      idx = int'(v.addr >> 2);
      @(negedge clk);
      address[d] = v.addr; read[d] = v.rd; write[d] = v.wr;
      writedata[d] = v.data; byteenable[d] = v.be;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (waitreq[d] !== 1'b0 && n < 64);
      check("ack_latency", d, n, wc[d] + 1);
      read[d] = 1'b0; write[d] = 1'b0;
      address[d] = 17'h1FFFF; writedata[d] = 32'hFFFF_FFFF; byteenable[d] = 4'hF;
      if (v.rd && !v.wr) begin
         sb_data[d].push_back(v.exp);
         sb_cyc[d].push_back(cyc + rl[d]);
      end
      @(negedge clk);
      check("ack_one_cycle", d, waitreq[d], 1'b1);
      if (v.wr && idx < 16) check("csr_word", d, csr[d][idx*32 +: 32], v.exp);
      if (v.rd && !v.wr) repeat (rl[d] - 1) @(negedge clk);
   endtask

   initial begin
      for (int d = 0; d < N; d++) begin
         address[d] = '0; read[d] = 1'b0; write[d] = 1'b0;
         writedata[d] = '0; byteenable[d] = '0;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset in the middle of a write's WAIT phase on the WAIT_CYCLES=3 instance.
      @(negedge clk);
      address[2] = 17'h000C; write[2] = 1'b1; writedata[2] = 32'hDEAD_BEEF; byteenable[2] = 4'hF;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_async_waitreq", 2, waitreq[2], 1'b1);
      @(negedge clk);
      write[2] = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      for (int d = 0; d < N; d++) begin
         check("rst_waitreq", d, waitreq[d], 1'b1);
         check("rst_rdv", d, rdv[d], 1'b0);
         check("rst_readdata", d, readdata[d], 32'h0);
         check("rst_csr0", d, csr[d][31:0], IdVal);
         check("rst_csr3", d, csr[d][3*32 +: 32], 32'h0);
      end
      repeat (6) @(negedge clk);
      check("rst_no_commit", 2, csr[2][3*32 +: 32], 32'h0);

      add(1, 0, 17'h0_0008, 32'h1234_5678, 4'hF, 32'h1234_5678);
      add(0, 1, 17'h0_0008, 32'h0,         4'hF, 32'h1234_5678);
      add(1, 0, 17'h0_000C, 32'h1234_5678, 4'hF, 32'h1234_5678);
      add(1, 0, 17'h0_000C, 32'hAABB_CCDD, 4'h5, 32'h12BB_56DD);
      add(0, 1, 17'h0_000C, 32'h0,         4'h0, 32'h12BB_56DD);
      add(1, 0, 17'h0_0000, 32'hFFFF_FFFF, 4'hF, IdVal);
      add(0, 1, 17'h0_0000, 32'h0,         4'hF, IdVal);
      add(0, 1, 17'h1_0000, 32'h0,         4'hF, Unm);
      add(1, 0, 17'h0_0040, 32'hDEAD_BEEF, 4'hF, 32'h0);
      add(0, 1, 17'h0_0040, 32'h0,         4'hF, Unm);
      add(1, 1, 17'h0_0004, 32'h0000_0055, 4'hF, 32'h0000_0055);
      add(0, 1, 17'h0_0004, 32'h0,         4'hF, 32'h0000_0055);
      add(0, 1, 17'h0_0008, 32'h0,         4'hF, 32'h1234_5678);

      for (int d = 0; d < N; d++) begin
         foreach (vecs[i]) run_vec(d, vecs[i]);
      end

      repeat (10) @(negedge clk);
      for (int d = 0; d < N; d++) check("sb_drained", d, sb_data[d].size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
